// File: rtl/ahb_ctrl_master.sv
// ahb_ctrl_master: single-outstanding AHB-Lite initiator bridging a valid/ready command port to AHB single transfers
// Ports: AHB_HCLK/AHB_HRESETn clock and async active-low reset; cmd_* command handshake
// (cmd_ready high only in IDLE); rsp_* one-cycle response pulse with read data, error and timeout flags;
// AHB_* master-side bus signals (word-sized SINGLE transfers, IDLE/NONSEQ only).
module ahb_ctrl_master #(
  parameter logic [3:0] HMASTER_ID     = 4'h1,
  parameter logic [3:0] HPROT_VAL      = 4'b0011,
  parameter int         TIMEOUT_CYCLES = 1023
) (
  input  logic        AHB_HCLK,
  input  logic        AHB_HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] AHB_HADDR,
  output logic [1:0]  AHB_HTRANS,
  output logic        AHB_HWRITE,
  output logic [2:0]  AHB_HSIZE,
  output logic [2:0]  AHB_HBURST,
  output logic [3:0]  AHB_HPROT,
  output logic        AHB_HMASTLOCK,
  output logic [3:0]  AHB_HMASTER,
  output logic [31:0] AHB_HWDATA,
  input  logic [31:0] AHB_HRDATA,
  input  logic        AHB_HREADY,
  input  logic [1:0]  AHB_HRESP
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t      state;
  logic [15:0] cnt;
  logic [31:0] wdata_q;
  assign cmd_ready     = state == IDLE;
  assign AHB_HSIZE     = 3'b010;
  assign AHB_HBURST    = 3'b000;
  assign AHB_HPROT     = HPROT_VAL;
  assign AHB_HMASTLOCK = 1'b0;
  assign AHB_HMASTER   = HMASTER_ID;
  always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn)
    if (!AHB_HRESETn) begin
      state       <= IDLE;
      cnt         <= '0;
      wdata_q     <= '0;
      AHB_HTRANS  <= 2'b00;
      AHB_HADDR   <= '0;
      AHB_HWRITE  <= 1'b0;
      AHB_HWDATA  <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else
      case (state)
        IDLE:
          if (cmd_valid) begin
            if (cmd_addr[1:0] != 2'b00) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state      <= ADDR;
              AHB_HTRANS <= 2'b10;
              AHB_HADDR  <= cmd_addr;
              AHB_HWRITE <= cmd_write;
              wdata_q    <= cmd_wdata;
            end
          end
        ADDR:
          if (AHB_HREADY) begin
            state      <= DATA;
            AHB_HTRANS <= 2'b00;
            AHB_HWDATA <= wdata_q;
            cnt        <= '0;
          end
        DATA:
          if (AHB_HREADY) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= AHB_HRESP != 2'b00;
            rsp_rdata <= (AHB_HRESP == 2'b00 && !AHB_HWRITE) ? AHB_HRDATA : '0;
            cnt       <= '0;
          end else if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            state       <= RESP;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            cnt         <= '0;
          end else
            cnt <= cnt + 16'd1;
        RESP: begin
          state       <= IDLE;
          rsp_valid   <= 1'b0;
          rsp_rdata   <= '0;
          rsp_err     <= 1'b0;
          rsp_timeout <= 1'b0;
        end
      endcase
endmodule
